// File: rtl/dispatch_sched.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_sched (with decode_pkg)
// Description : Single-slot dispatcher steering decoded uops to ALU/BRU/LSU/
//               MDU/SYS queues; serialises CSR/FENCE/ECALL/EBREAK/MRET.
// Revision    : 1.0 - initial release
// ============================================================================

package decode_pkg;

    typedef enum logic [2:0] {
        FU_NONE   = 3'd0,
        FU_ALU    = 3'd1,
        FU_BRANCH = 3'd2,
        FU_LSU    = 3'd3,
        FU_MUL    = 3'd4,
        FU_DIV    = 3'd5
    } fu_e;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        fu_e         fu;
        logic        is_csr;
        logic        is_fence;
        logic        is_ecall;
        logic        is_ebreak;
        logic        is_mret;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } uop_t;

endpackage

module dispatch_sched #(
    parameter int CNT_W     = 32,
    parameter int DRAIN_MAX = 1023
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  flush_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [$bits(decode_pkg::uop_t)-1:0]   in_uop_i,
    input  logic                                  rob_empty_i,
    output logic [$bits(decode_pkg::uop_t)-1:0]   uop_o,
    output logic                                  alu_valid_o,
    input  logic                                  alu_ready_i,
    output logic                                  bru_valid_o,
    input  logic                                  bru_ready_i,
    output logic                                  lsu_valid_o,
    input  logic                                  lsu_ready_i,
    output logic                                  mdu_valid_o,
    input  logic                                  mdu_ready_i,
    output logic                                  sys_valid_o,
    input  logic                                  sys_ready_i,
    input  logic                                  sys_done_i,
    output logic [CNT_W-1:0]                      ser_stall_cnt_o,
    output logic                                  drain_timeout_o
);

    import decode_pkg::*;

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_drain = 2'd1;
    localparam logic [1:0] c_st_issue = 2'd2;
    localparam logic [1:0] c_st_wait  = 2'd3;

    localparam int c_ri_alu = 0;
    localparam int c_ri_bru = 1;
    localparam int c_ri_lsu = 2;
    localparam int c_ri_mdu = 3;
    localparam int c_ri_sys = 4;

    localparam int              c_dc_w       = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX + 1);
    localparam logic [c_dc_w-1:0] c_drain_max  = c_dc_w'(DRAIN_MAX);
    localparam logic [c_dc_w-1:0] c_drain_last = c_dc_w'((DRAIN_MAX > 0) ? DRAIN_MAX - 1 : 0);

    // Illegal uops go to the ALU even if they look serialising: the ALU raises the exception.
    function automatic logic is_ser(input uop_t u);
        return !u.illegal & (u.is_csr | u.is_fence | u.is_ecall | u.is_ebreak | u.is_mret);
    endfunction

    function automatic logic [4:0] route_of(input uop_t u);
        logic [4:0] r;
        r = '0;
        if (u.illegal) begin
            r[c_ri_alu] = 1'b1;
        end else if (is_ser(u)) begin
            r[c_ri_sys] = 1'b1;
        end else begin
            case (u.fu)
                FU_BRANCH:      r[c_ri_bru] = 1'b1;
                FU_LSU:         r[c_ri_lsu] = 1'b1;
                FU_MUL, FU_DIV: r[c_ri_mdu] = 1'b1;
                default:        r[c_ri_alu] = 1'b1;
            endcase
        end
        return r;
    endfunction

    logic [1:0]        r_state;
    logic              r_slot_valid;
    logic [4:0]        r_slot_route;
    uop_t              r_uop;
    uop_t              r_pend_uop;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [c_dc_w-1:0] r_drain_cnt;
    logic              r_timeout;

    uop_t       w_in_uop;
    logic [4:0] w_valid_vec;
    logic [4:0] w_ready_vec;
    logic       w_fire;
    logic       w_sys_fire;
    logic       w_in_ready;
    logic       w_take;
    logic       w_take_ser;
    logic       w_take_norm;

    assign w_in_uop    = uop_t'(in_uop_i);
    assign w_valid_vec = {5{r_slot_valid}} & r_slot_route;
    assign w_ready_vec = {sys_ready_i, mdu_ready_i, lsu_ready_i, bru_ready_i, alu_ready_i};
    assign w_fire      = |(w_valid_vec & w_ready_vec);
    assign w_sys_fire  = w_valid_vec[c_ri_sys] & sys_ready_i;

    assign w_in_ready  = (r_state == c_st_run) & !flush_i & (!r_slot_valid | w_fire);
    // A handshake with valid = 0 is consumed but loads nothing.
    assign w_take      = in_valid_i & w_in_ready & w_in_uop.valid;
    assign w_take_ser  = w_take & is_ser(w_in_uop);
    assign w_take_norm = w_take & !is_ser(w_in_uop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= c_st_run;
            r_slot_valid <= 1'b0;
            r_slot_route <= '0;
            r_uop        <= '0;
            r_pend_uop   <= '0;
        end else if (flush_i) begin
            r_state      <= c_st_run;
            r_slot_valid <= 1'b0;
            r_slot_route <= '0;
            r_uop        <= '0;
            r_pend_uop   <= '0;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (w_take_norm) begin
                        r_slot_valid <= 1'b1;
                        r_slot_route <= route_of(w_in_uop);
                        r_uop        <= w_in_uop;
                    end else if (w_fire) begin
                        r_slot_valid <= 1'b0;
                    end
                    if (w_take_ser) begin
                        r_pend_uop <= w_in_uop;
                        r_state    <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    if (!r_slot_valid && rob_empty_i) begin
                        r_slot_valid <= 1'b1;
                        r_slot_route <= route_of(r_pend_uop);
                        r_uop        <= r_pend_uop;
                        r_pend_uop   <= '0;
                        r_state      <= c_st_issue;
                    end else if (w_fire) begin
                        r_slot_valid <= 1'b0;
                    end
                end
                c_st_issue: begin
                    if (w_sys_fire) begin
                        r_slot_valid <= 1'b0;
                        r_state      <= sys_done_i ? c_st_run : c_st_wait;
                    end
                end
                default: begin
                    if (sys_done_i) begin
                        r_state <= c_st_run;
                    end
                end
            endcase
        end
    end

    // Stall counter and timeout survive flushes; only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state != c_st_run) && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_drain_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_state == c_st_run) begin
                r_drain_cnt <= '0;
            end else if ((r_state == c_st_drain) && (r_drain_cnt != c_drain_max)) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
            if ((DRAIN_MAX != 0) && (r_state == c_st_drain) && (r_drain_cnt == c_drain_last)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign in_ready_o      = w_in_ready;
    assign uop_o           = r_uop;
    assign alu_valid_o     = w_valid_vec[c_ri_alu];
    assign bru_valid_o     = w_valid_vec[c_ri_bru];
    assign lsu_valid_o     = w_valid_vec[c_ri_lsu];
    assign mdu_valid_o     = w_valid_vec[c_ri_mdu];
    assign sys_valid_o     = w_valid_vec[c_ri_sys];
    assign ser_stall_cnt_o = r_stall_cnt;
    assign drain_timeout_o = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_dispatch_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_sched
// Description : Directed table-driven bench plus serialisation/flush/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_dispatch_sched;

    import decode_pkg::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    uop_t       in_uop;
    logic       rob_empty;
    uop_t       uop_out;
    logic [4:0] rdy;
    logic [4:0] vv;
    logic       sys_done;
    logic [3:0] stall_cnt;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    dispatch_sched #(
        .CNT_W     (4),
        .DRAIN_MAX (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_uop_i        (in_uop),
        .rob_empty_i     (rob_empty),
        .uop_o           (uop_out),
        .alu_valid_o     (vv[0]),
        .alu_ready_i     (rdy[0]),
        .bru_valid_o     (vv[1]),
        .bru_ready_i     (rdy[1]),
        .lsu_valid_o     (vv[2]),
        .lsu_ready_i     (rdy[2]),
        .mdu_valid_o     (vv[3]),
        .mdu_ready_i     (rdy[3]),
        .sys_valid_o     (vv[4]),
        .sys_ready_i     (rdy[4]),
        .sys_done_i      (sys_done),
        .ser_stall_cnt_o (stall_cnt),
        .drain_timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serialising-kind encodings {csr, fence, ecall, ebreak, mret}
    localparam logic [4:0] K_NONE   = 5'b00000;
    localparam logic [4:0] K_CSR    = 5'b10000;
    localparam logic [4:0] K_FENCE  = 5'b01000;
    localparam logic [4:0] K_ECALL  = 5'b00100;
    localparam logic [4:0] K_EBREAK = 5'b00010;
    localparam logic [4:0] K_MRET   = 5'b00001;

    typedef struct {
        logic        iv;
        uop_t        u;
        logic [4:0]  rdy;
        logic        exp_ir;
        logic [4:0]  exp_v;
        logic        chk_pc;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt[$];

    function automatic uop_t mk(input logic v, input logic ill, input fu_e fu,
                                input logic [4:0] k, input logic [31:0] pc);
        uop_t u;
        u = '0;
        u.valid   = v;
        u.illegal = ill;
        u.fu      = fu;
        {u.is_csr, u.is_fence, u.is_ecall, u.is_ebreak, u.is_mret} = k;
        u.pc      = pc;
        u.rd      = pc[4:0];
        return u;
    endfunction

    function automatic void add(input logic iv, input uop_t u, input logic [4:0] r,
                                input logic eir, input logic [4:0] ev,
                                input logic cpc, input logic [31:0] epc);
        vec_t v;
        v.iv = iv; v.u = u; v.rdy = r; v.exp_ir = eir; v.exp_v = ev;
        v.chk_pc = cpc; v.exp_pc = epc;
        vt.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step_in(input logic iv, input uop_t u, input logic rob,
                           input logic done, input logic fl);
        in_valid  = iv;
        in_uop    = u;
        rob_empty = rob;
        sys_done  = done;
        flush     = fl;
        rdy       = 5'b11111;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    uop_t z;

    initial begin
        z = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_uop = '0;
        rob_empty = 1'b1; sys_done = 1'b0; rdy = 5'b11111;

        // Vector table: each row is one cycle; expectations are outputs seen before that cycle's edge.
        add(1, mk(1,0,FU_ALU,   K_NONE,1),  5'b11111, 1, 5'b00000, 1, 0);
        add(1, mk(1,0,FU_LSU,   K_NONE,2),  5'b11111, 1, 5'b00001, 1, 1);
        add(1, mk(1,0,FU_MUL,   K_NONE,3),  5'b11111, 1, 5'b00100, 1, 2);
        add(1, mk(1,0,FU_BRANCH,K_NONE,4),  5'b11111, 1, 5'b01000, 1, 3);
        add(1, mk(1,0,FU_DIV,   K_NONE,5),  5'b11111, 1, 5'b00010, 1, 4);
        add(0, z,                           5'b11111, 1, 5'b01000, 1, 5);
        add(0, z,                           5'b11111, 1, 5'b00000, 0, 0);
        add(1, mk(1,0,FU_LSU,   K_NONE,10), 5'b11111, 1, 5'b00000, 0, 0);
        add(1, mk(1,0,FU_ALU,   K_NONE,11), 5'b11011, 0, 5'b00100, 1, 10);
        add(1, mk(1,0,FU_ALU,   K_NONE,11), 5'b11011, 0, 5'b00100, 1, 10);
        add(1, mk(1,0,FU_ALU,   K_NONE,11), 5'b11011, 0, 5'b00100, 1, 10);
        add(1, mk(1,0,FU_ALU,   K_NONE,11), 5'b11111, 1, 5'b00100, 1, 10);
        add(0, z,                           5'b11111, 1, 5'b00001, 1, 11);
        add(0, z,                           5'b11111, 1, 5'b00000, 0, 0);
        add(1, mk(1,1,FU_LSU,   K_NONE,20), 5'b11111, 1, 5'b00000, 0, 0);
        add(1, mk(1,0,FU_NONE,  K_NONE,21), 5'b11111, 1, 5'b00001, 1, 20);
        add(1, mk(0,0,FU_LSU,   K_NONE,22), 5'b11111, 1, 5'b00001, 1, 21);
        add(0, z,                           5'b11111, 1, 5'b00000, 0, 0);

        adv(); adv();
        chk("rst_valids", 32'(vv), 0);
        chk("rst_uop_pc", uop_out.pc, 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst = 1'b0;

        foreach (vt[i]) begin
            in_valid = vt[i].iv; in_uop = vt[i].u; rdy = vt[i].rdy;
            rob_empty = 1'b1; sys_done = 1'b0; flush = 1'b0;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].exp_ir));
            chk($sformatf("vec%0d_valids", i), 32'(vv), 32'(vt[i].exp_v));
            if (vt[i].chk_pc) chk($sformatf("vec%0d_uop_pc", i), uop_out.pc, vt[i].exp_pc);
            adv();
        end

        // CSR with ROB busy for 5 cycles; timeout fires after 4 DRAIN cycles
        chk("csr_cnt_pre", 32'(stall_cnt), 0);
        chk("csr_tmo_pre", 32'(timeout), 0);
        step_in(1, mk(1,0,FU_ALU,K_CSR,30), 0, 0, 0);
        chk("csr_accept", 32'(in_ready), 1);
        adv();
        for (int k = 1; k <= 5; k++) begin
            step_in(1, mk(1,0,FU_ALU,K_NONE,31), 0, 0, 0);
            chk($sformatf("drain%0d_in_ready", k), 32'(in_ready), 0);
            chk($sformatf("drain%0d_sys_valid", k), 32'(vv[4]), 0);
            chk($sformatf("drain%0d_cnt", k), 32'(stall_cnt), 32'(k - 1));
            chk($sformatf("drain%0d_timeout", k), 32'(timeout), (k == 5) ? 1 : 0);
            adv();
        end
        step_in(1, mk(1,0,FU_ALU,K_NONE,31), 1, 0, 0);
        chk("rob_empty_in_ready", 32'(in_ready), 0);
        chk("rob_empty_sys_valid", 32'(vv[4]), 0);
        adv();
        step_in(1, mk(1,0,FU_ALU,K_NONE,31), 1, 0, 0);
        chk("issue_valids", 32'(vv), 32'b10000);
        chk("issue_uop_pc", uop_out.pc, 30);
        chk("issue_in_ready", 32'(in_ready), 0);
        chk("issue_cnt", 32'(stall_cnt), 6);
        adv();
        step_in(1, mk(1,0,FU_ALU,K_NONE,31), 1, 0, 0);
        chk("wait_valids", 32'(vv), 0);
        chk("wait_in_ready", 32'(in_ready), 0);
        adv();
        step_in(1, mk(1,0,FU_ALU,K_NONE,31), 1, 1, 0);
        chk("done_in_ready", 32'(in_ready), 0);
        chk("done_cnt", 32'(stall_cnt), 8);
        adv();
        step_in(1, mk(1,0,FU_ALU,K_NONE,31), 1, 0, 0);
        chk("post_run_in_ready", 32'(in_ready), 1);
        chk("post_run_cnt", 32'(stall_cnt), 9);
        adv();
        step_in(0, z, 1, 0, 0);
        chk("post_alu_valids", 32'(vv), 32'b00001);
        chk("post_alu_pc", uop_out.pc, 31);
        chk("post_alu_cnt", 32'(stall_cnt), 9);
        adv();

        // MRET with fu = ALU serialised, then flushed while in WAIT
        step_in(1, mk(1,0,FU_ALU,K_MRET,40), 1, 0, 0);
        chk("mret_accept", 32'(in_ready), 1);
        adv();
        step_in(0, z, 1, 0, 0);
        chk("mret_drain_in_ready", 32'(in_ready), 0);
        adv();
        step_in(0, z, 1, 0, 0);
        chk("mret_sys_valids", 32'(vv), 32'b10000);
        chk("mret_uop_pc", uop_out.pc, 40);
        adv();
        step_in(0, z, 1, 0, 1);
        chk("wflush_in_ready", 32'(in_ready), 0);
        adv();
        step_in(0, z, 1, 0, 0);
        chk("wflush_valids", 32'(vv), 0);
        chk("wflush_in_ready_after", 32'(in_ready), 1);
        chk("wflush_cnt", 32'(stall_cnt), 12);
        chk("wflush_timeout", 32'(timeout), 1);
        adv();

        // Pending FENCE flushed during DRAIN must never issue
        step_in(1, mk(1,0,FU_NONE,K_FENCE,50), 0, 0, 0);
        chk("fence_accept", 32'(in_ready), 1);
        adv();
        step_in(0, z, 0, 0, 0);
        chk("fence_drain_in_ready", 32'(in_ready), 0);
        adv();
        step_in(0, z, 0, 0, 1);
        chk("dflush_in_ready", 32'(in_ready), 0);
        adv();
        step_in(0, z, 1, 0, 0);
        chk("dflush_in_ready_after", 32'(in_ready), 1);
        chk("dflush_valids", 32'(vv), 0);
        chk("dflush_cnt", 32'(stall_cnt), 14);
        chk("dflush_timeout_sticky", 32'(timeout), 1);
        adv();
        for (int k = 0; k < 3; k++) begin
            step_in(0, z, 1, 0, 0);
            chk($sformatf("fence_gone%0d", k), 32'(vv[4]), 0);
            adv();
        end

        // ECALL with sys_done on the issue handshake; counter saturates at 15
        step_in(1, mk(1,0,FU_ALU,K_ECALL,60), 1, 0, 0);
        adv();
        step_in(0, z, 1, 0, 0);
        adv();
        step_in(0, z, 1, 1, 0);
        chk("ecall_sys_valids", 32'(vv), 32'b10000);
        adv();
        step_in(0, z, 1, 0, 0);
        chk("ecall_direct_run", 32'(in_ready), 1);
        chk("cnt_saturate", 32'(stall_cnt), 15);
        adv();
        step_in(1, mk(1,0,FU_ALU,K_EBREAK,70), 1, 0, 0);
        adv();
        step_in(0, z, 1, 0, 0);
        adv();
        step_in(0, z, 1, 0, 0);
        adv();
        step_in(0, z, 1, 1, 0);
        adv();
        step_in(0, z, 1, 0, 0);
        chk("cnt_hold_sat", 32'(stall_cnt), 15);
        chk("ebreak_run", 32'(in_ready), 1);
        adv();

        // Asynchronous reset in the middle of DRAIN
        step_in(1, mk(1,0,FU_ALU,K_CSR,80), 0, 0, 0);
        adv();
        step_in(0, z, 0, 0, 0);
        adv();
        #2 rst = 1'b1;
        #1;
        chk("arst_valids", 32'(vv), 0);
        chk("arst_uop_pc", uop_out.pc, 0);
        chk("arst_cnt", 32'(stall_cnt), 0);
        chk("arst_timeout", 32'(timeout), 0);
        #1 rst = 1'b0;
        adv();
        step_in(1, mk(1,0,FU_ALU,K_NONE,90), 1, 0, 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        adv();
        step_in(0, z, 1, 0, 0);
        chk("arst_alu_valids", 32'(vv), 32'b00001);
        chk("arst_alu_pc", uop_out.pc, 90);
        adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
